// File: rtl/audio_fixed_pkg.sv
// rtl/audio_fixed_pkg.sv - shared audio sample types, limits and combiner states
// Q1.15 sample format used across the band processing chain.
package audio_fixed_pkg;

  localparam int NUM_BANDS = 4;

  typedef logic signed [15:0] audio_sample_t;
  typedef audio_sample_t [NUM_BANDS-1:0] audio_band_array_t;

  localparam audio_sample_t SAMPLE_MAX = 16'sh7FFF;
  localparam audio_sample_t SAMPLE_MIN = 16'sh8000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    OUT   = 2'd2
  } combiner_state_e;

  // Negation that stays in range: the most negative code maps to full scale.
  function automatic audio_sample_t neg_sat(input audio_sample_t x);
    return (x == SAMPLE_MIN) ? SAMPLE_MAX : -x;
  endfunction

endpackage

// File: rtl/band_align_fifo.sv
// rtl/band_align_fifo.sv - single-clock alignment FIFO for one audio band
// A push into a full FIFO is only accepted when a pop happens in the same cycle.
module band_align_fifo
  import audio_fixed_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  audio_sample_t            din,
  output audio_sample_t            dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  audio_sample_t  r_mem [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [AW:0]    r_count;
  logic           w_do_push;
  logic           w_do_pop;

  assign full      = (r_count == (AW+1)'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign dout      = r_mem[r_rd_ptr];
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/band_combiner.sv
// rtl/band_combiner.sv - aligns per-band samples, sums them serially, scales and saturates
// Optional band polarity inversion is enabled by defining BAND_POLARITY_EN.
module band_combiner
  import audio_fixed_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int OUT_SHIFT  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  audio_band_array_t    band_in,
  input  logic [NUM_BANDS-1:0] band_in_valid,
`ifdef BAND_POLARITY_EN
  input  logic [NUM_BANDS-1:0] band_invert,
`endif
  output audio_sample_t        data_out,
  output logic                 data_out_valid,
  output logic                 clip,
  output logic                 fifo_overflow
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int IDX_W = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
  localparam int ACC_W = 16 + $clog2(NUM_BANDS) + 1;
  localparam logic signed [ACC_W-1:0] ACC_MAX = {{(ACC_W-16){1'b0}}, SAMPLE_MAX};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {{(ACC_W-16){1'b1}}, SAMPLE_MIN};

  combiner_state_e          r_state;
  combiner_state_e          w_state_nxt;
  audio_sample_t            r_snap [NUM_BANDS];
  logic signed [ACC_W-1:0]  r_acc;
  logic [IDX_W-1:0]         r_idx;
  audio_sample_t            r_dout;
  logic                     r_valid;
  logic                     r_clip;
  logic                     r_ovf;

  audio_sample_t            w_head [NUM_BANDS];
  logic [CNT_W-1:0]         w_count [NUM_BANDS];
  logic [NUM_BANDS-1:0]     w_full;
  logic [NUM_BANDS-1:0]     w_empty;
  logic [NUM_BANDS-1:0]     w_push;
  logic [NUM_BANDS-1:0]     w_pop;
  logic [NUM_BANDS-1:0]     w_ready;
  logic                     w_take;
  audio_sample_t            w_sel;
  audio_sample_t            w_term;
  logic signed [ACC_W-1:0]  w_term_ext;
  logic signed [ACC_W-1:0]  w_shifted;
  audio_sample_t            w_clamped;
  logic                     w_clip;

  for (genvar b = 0; b < NUM_BANDS; b++) begin : g_band
    assign w_push[b]  = en & band_in_valid[b];
    assign w_pop[b]   = w_take & ~w_empty[b];
    assign w_ready[b] = (w_count[b] != '0);

    band_align_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (w_push[b]),
      .pop   (w_pop[b]),
      .din   (band_in[b]),
      .dout  (w_head[b]),
      .count (w_count[b]),
      .full  (w_full[b]),
      .empty (w_empty[b])
    );
  end

  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    case (r_state)
      IDLE:    if (en && (&w_ready)) begin
                 w_take      = 1'b1;
                 w_state_nxt = ACCUM;
               end
      ACCUM:   if (en && (r_idx == IDX_W'(NUM_BANDS-1))) w_state_nxt = OUT;
      OUT:     if (en) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  assign w_sel = r_snap[r_idx];
`ifdef BAND_POLARITY_EN
  logic [NUM_BANDS-1:0] r_inv;
  assign w_term = r_inv[r_idx] ? neg_sat(w_sel) : w_sel;
`else
  assign w_term = w_sel;
`endif
  assign w_term_ext = {{(ACC_W-16){w_term[15]}}, w_term};
  assign w_shifted  = r_acc >>> OUT_SHIFT;

  always_comb begin
    w_clamped = w_shifted[15:0];
    w_clip    = 1'b0;
    if (w_shifted > ACC_MAX) begin
      w_clamped = SAMPLE_MAX;
      w_clip    = 1'b1;
    end else if (w_shifted < ACC_MIN) begin
      w_clamped = SAMPLE_MIN;
      w_clip    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < NUM_BANDS; b++) r_snap[b] <= '0;
`ifdef BAND_POLARITY_EN
      r_inv   <= '0;
`endif
      r_acc   <= '0;
      r_idx   <= '0;
      r_dout  <= '0;
      r_valid <= 1'b0;
      r_clip  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_clip  <= 1'b0;
      // w_push is already gated by en, so a frozen block never flags overflow
      if (|(w_push & w_full & ~w_pop)) r_ovf <= 1'b1;
      if (w_take) begin
        for (int b = 0; b < NUM_BANDS; b++) r_snap[b] <= w_head[b];
`ifdef BAND_POLARITY_EN
        r_inv <= band_invert;
`endif
        r_acc <= '0;
        r_idx <= '0;
      end
      if (en && r_state == ACCUM) begin
        r_acc <= r_acc + w_term_ext;
        r_idx <= r_idx + IDX_W'(1);
      end
      if (en && r_state == OUT) begin
        r_dout  <= w_clamped;
        r_valid <= 1'b1;
        r_clip  <= w_clip;
      end
    end
  end

  assign data_out       = r_dout;
  assign data_out_valid = r_valid & en;
  assign clip           = r_clip & en;
  assign fifo_overflow  = r_ovf;

endmodule

// File: tb/tb_band_combiner.sv
// tb/tb_band_combiner.sv - self-checking bench for band_combiner (OUT_SHIFT 0 and 2)
// Build with BAND_POLARITY_EN defined to also exercise band inversion.
module tb_band_combiner;
  import audio_fixed_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  audio_band_array_t band_in;
  logic [3:0]        band_in_valid;
  logic [3:0]        inv_now;
  audio_sample_t     data_out0, data_out2;
  logic              valid0, valid2, clip0, clip2, ovf0, ovf2;
  int                cyc = 0;
  int                n_cmp = 0;
  int                n_fail = 0;

  typedef struct {
    logic [15:0] d;
    logic        c;
    int          t;
  } exp_t;

  typedef struct {
    logic [3:0][15:0] b;
    logic [15:0]      d0;
    logic             c0;
    logic [15:0]      d2;
    logic             c2;
  } vec_t;

  exp_t q0[$];
  exp_t q2[$];
  vec_t vecs[8];

  band_combiner #(.FIFO_DEPTH(4), .OUT_SHIFT(0)) u_dut0 (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .band_in        (band_in),
    .band_in_valid  (band_in_valid),
`ifdef BAND_POLARITY_EN
    .band_invert    (inv_now),
`endif
    .data_out       (data_out0),
    .data_out_valid (valid0),
    .clip           (clip0),
    .fifo_overflow  (ovf0)
  );

  band_combiner #(.FIFO_DEPTH(4), .OUT_SHIFT(2)) u_dut2 (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .band_in        (band_in),
    .band_in_valid  (band_in_valid),
`ifdef BAND_POLARITY_EN
    .band_invert    (inv_now),
`endif
    .data_out       (data_out2),
    .data_out_valid (valid2),
    .clip           (clip2),
    .fifo_overflow  (ovf2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] mask, input int v0, input int v1, input int v2, input int v3);
    band_in[0]    = 16'(v0);
    band_in[1]    = 16'(v1);
    band_in[2]    = 16'(v2);
    band_in[3]    = 16'(v3);
    band_in_valid = mask;
    tick();
    band_in_valid = '0;
  endtask

  function automatic void model(input int v0, input int v1, input int v2, input int v3,
                                input logic [3:0] inv, input int sh,
                                output logic [15:0] d, output logic c);
    int v[4];
    int s;
    v = '{v0, v1, v2, v3};
    s = 0;
    for (int b = 0; b < 4; b++) begin
      if (inv[b]) s += (v[b] == -32768) ? 32767 : -v[b];
      else        s += v[b];
    end
    s = s >>> sh;
    c = 1'b1;
    if (s > 32767)       d = 16'h7FFF;
    else if (s < -32768) d = 16'h8000;
    else begin
      d = 16'(s);
      c = 1'b0;
    end
  endfunction

  task automatic model_push(input int v0, input int v1, input int v2, input int v3, input int t);
    exp_t e;
    model(v0, v1, v2, v3, inv_now, 0, e.d, e.c);
    e.t = t;
    q0.push_back(e);
    model(v0, v1, v2, v3, inv_now, 2, e.d, e.c);
    q2.push_back(e);
  endtask

  function automatic vec_t mk(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                              input logic [15:0] d, input logic [15:0] d0, input logic c0,
                              input logic [15:0] d2, input logic c2);
    vec_t r;
    r.b[0] = a; r.b[1] = b; r.b[2] = c; r.b[3] = d;
    r.d0 = d0; r.c0 = c0; r.d2 = d2; r.c2 = c2;
    return r;
  endfunction

  task automatic mon(input int id, input logic [15:0] d, input logic v, input logic c);
    exp_t  e;
    string sfx;
    sfx = (id == 0) ? "s0" : "s2";
    if (!v) begin
      check({"clip_idle_", sfx}, int'(c), 0);
      return;
    end
    if ((id == 0 && q0.size() == 0) || (id != 0 && q2.size() == 0)) begin
      n_cmp++;
      n_fail++;
      $display("FAIL unexpected_out_%s: got data %0d, expected no output (cycle %0d)", sfx, d, cyc);
      return;
    end
    if (id == 0) e = q0.pop_front();
    else         e = q2.pop_front();
    check({"data_", sfx}, int'(d), int'(e.d));
    check({"clip_", sfx}, int'(c), int'(e.c));
    if (e.t >= 0) check({"valid_cycle_", sfx}, cyc, e.t);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon(0, data_out0, valid0, clip0);
      mon(2, data_out2, valid2, clip2);
    end
  end

  task automatic wait_drain(input int max);
    int k;
    k = 0;
    while ((q0.size() != 0 || q2.size() != 0) && k < max) begin
      tick();
      k++;
    end
    check("drain_pending", q0.size() + q2.size(), 0);
    q0.delete();
    q2.delete();
  endtask

  initial begin
    rst           = 1'b1;
    en            = 1'b1;
    band_in       = '0;
    band_in_valid = '0;
    inv_now       = '0;

    vecs[0] = mk(16'h1000, 16'h0800, 16'h0400, 16'h0200, 16'h1E00, 1'b0, 16'h0780, 1'b0);
    vecs[1] = mk(16'h7000, 16'h7000, 16'h7000, 16'h7000, 16'h7FFF, 1'b1, 16'h7000, 1'b0);
    vecs[2] = mk(16'h9000, 16'h9000, 16'h9000, 16'h9000, 16'h8000, 1'b1, 16'h9000, 1'b0);
    vecs[3] = mk(16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);
    vecs[4] = mk(16'h7FFF, 16'h0001, 16'h0000, 16'h0000, 16'h7FFF, 1'b1, 16'h2000, 1'b0);
    vecs[5] = mk(16'h8000, 16'hFFFF, 16'h0000, 16'h0000, 16'h8000, 1'b1, 16'hDFFF, 1'b0);
    vecs[6] = mk(16'h8000, 16'h0000, 16'h0000, 16'h0000, 16'h8000, 1'b0, 16'hE000, 1'b0);
    vecs[7] = mk(16'h0064, 16'hFFCE, 16'h0019, 16'hFF38, 16'hFF83, 1'b0, 16'hFFE0, 1'b0);

    repeat (3) tick();
    check("rst_data_s0", int'(data_out0), 0);
    check("rst_valid_s0", int'(valid0), 0);
    check("rst_clip_s0", int'(clip0), 0);
    check("rst_ovf_s0", int'(ovf0), 0);
    check("rst_data_s2", int'(data_out2), 0);
    check("rst_valid_s2", int'(valid2), 0);
    rst = 1'b0;
    tick();

    // All bands in the same cycle: output exactly 7 cycles later
    for (int i = 0; i < 8; i++) begin
      exp_t e;
      e.t = cyc + 7;
      e.d = vecs[i].d0; e.c = vecs[i].c0; q0.push_back(e);
      e.d = vecs[i].d2; e.c = vecs[i].c2; q2.push_back(e);
      drive(4'hF, int'(vecs[i].b[0]), int'(vecs[i].b[1]), int'(vecs[i].b[2]), int'(vecs[i].b[3]));
      wait_drain(20);
    end

    // Staggered arrival at offsets 0, 3, 5, 9: single output at offset 16
    drive(4'b0001, 100, 0, 0, 0);
    repeat (2) tick();
    drive(4'b0010, 0, 100, 0, 0);
    tick();
    drive(4'b0100, 0, 0, 100, 0);
    repeat (3) tick();
    model_push(100, 100, 100, 100, cyc + 7);
    drive(4'b1000, 0, 0, 0, 100);
    wait_drain(30);

    // Band 0 overruns its FIFO; the fifth sample is dropped
    check("ovf_before_s0", int'(ovf0), 0);
    for (int i = 0; i < 5; i++) drive(4'b0001, 11 * (i + 1), 0, 0, 0);
    tick();
    check("ovf_set_s0", int'(ovf0), 1);
    check("ovf_set_s2", int'(ovf2), 1);
    for (int k = 0; k < 4; k++) begin
      model_push(11 * (k + 1), k + 1, 2 * (k + 1), 3 * (k + 1), -1);
      drive(4'b1110, 0, k + 1, 2 * (k + 1), 3 * (k + 1));
    end
    wait_drain(60);
    repeat (10) tick();
    check("ovf_sticky_s0", int'(ovf0), 1);

    // Reset during ACCUM with a second set still buffered
    drive(4'hF, 500, 500, 500, 500);
    drive(4'hF, 600, 600, 600, 600);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("ovf_cleared_s0", int'(ovf0), 0);
    check("ovf_cleared_s2", int'(ovf2), 0);
    drive(4'b0111, 7, 7, 7, 0);
    repeat (12) tick();
    model_push(7, 7, 7, 9, cyc + 7);
    drive(4'b1000, 0, 0, 0, 9);
    wait_drain(30);

    // en low for 10 cycles mid-ACCUM; writes while frozen are ignored
    model_push(1, 2, 3, 4, cyc + 17);
    drive(4'hF, 1, 2, 3, 4);
    repeat (2) tick();
    en = 1'b0;
    drive(4'hF, 1111, 2222, 3333, 4444);
    repeat (9) tick();
    en = 1'b1;
    wait_drain(40);
    check("ovf_after_en_s0", int'(ovf0), 0);

`ifdef BAND_POLARITY_EN
    inv_now = 4'b0010;
    model_push(1000, -32768, 0, 0, cyc + 7);
    drive(4'hF, 1000, -32768, 0, 0);
    wait_drain(20);
    inv_now = 4'b1111;
    model_push(100, 200, -350, 0, cyc + 7);
    drive(4'hF, 100, 200, -350, 0);
    tick();
    inv_now = 4'b0000;
    wait_drain(20);
`endif

    repeat (5) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
